// File: rtl/rom_socket_arbiter.sv
// Two 2764-style ROM sockets sharing one single-port block ROM.
// Socket reads are cached per socket by address tag and serialised round-robin onto the ROM port.
module rom_socket_arbiter #(
  parameter int         MEM_LATENCY = 1,
  parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
  input  logic        clk_14M,
  input  logic        reset_n,
  input  logic        diag_ce_n,
  input  logic        diag_oe_n,
  input  logic [12:0] diag_a,
  output logic [7:0]  diag_d,
  output logic        diag_rdy,
  input  logic        mon_ce_n,
  input  logic        mon_oe_n,
  input  logic [12:0] mon_a,
  output logic [7:0]  mon_d,
  output logic        mon_rdy,
  output logic        mem_en,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t      r_state;
  logic        r_sel;
  logic        r_last_grant;
  logic        r_mem_en;
  logic [13:0] r_mem_addr;
  logic [1:0]  r_cnt;
  logic [7:0]  r_d [2];
  logic [12:0] r_t [2];
  logic [1:0]  r_v;

  logic [1:0]  w_ce_n;
  logic [1:0]  w_oe_n;
  logic [1:0]  w_hit;
  logic [1:0]  w_pend;
  logic [1:0]  w_rdy;
  logic [12:0] w_a [2];
  logic [7:0]  w_d [2];
  logic        w_grant;

  // Index 0 is the diagnostics socket, index 1 the monitor socket (also the ROM address MSB).
  assign w_ce_n = {mon_ce_n, diag_ce_n};
  assign w_oe_n = {mon_oe_n, diag_oe_n};
  assign w_a[0] = diag_a;
  assign w_a[1] = mon_a;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sock
      assign w_hit[gi]  = r_v[gi] && (r_t[gi] == w_a[gi]);
      assign w_pend[gi] = !w_ce_n[gi] && !w_hit[gi];
      assign w_rdy[gi]  = !w_ce_n[gi] && w_hit[gi];
      assign w_d[gi]    = (!w_ce_n[gi] && !w_oe_n[gi]) ? r_d[gi] : IDLE_DATA;
    end
  endgenerate

  // On a tie the socket that was not served last wins.
  assign w_grant = (w_pend[0] && w_pend[1]) ? ~r_last_grant : w_pend[1];

  assign diag_d   = w_d[0];
  assign diag_rdy = w_rdy[0];
  assign mon_d    = w_d[1];
  assign mon_rdy  = w_rdy[1];
  assign mem_en   = r_mem_en;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_cnt        <= '0;
      r_d[0]       <= IDLE_DATA;
      r_d[1]       <= IDLE_DATA;
      r_t[0]       <= '0;
      r_t[1]       <= '0;
      r_v          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pend) begin
            r_sel      <= w_grant;
            r_mem_addr <= {w_grant, w_a[w_grant]};
            r_mem_en   <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_cnt    <= 2'(MEM_LATENCY - 1);
          r_state  <= WAIT;
        end
        // WAIT spans MEM_LATENCY cycles, so CAPTURE samples mem_dout a cycle after it settles.
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= CAPTURE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        CAPTURE: begin
          r_d[r_sel]   <= mem_dout;
          r_t[r_sel]   <= r_mem_addr[12:0];
          r_v[r_sel]   <= 1'b1;
          r_last_grant <= r_sel;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_socket_arbiter.sv
// Directed bench: one arbiter with a 1-cycle ROM and one with a 3-cycle ROM,
// both fed from a shared ROM image with known bytes at the addresses exercised.
module tb_rom_socket_arbiter;

  logic clk;
  logic reset_n;

  logic        d_ce_n, d_oe_n, m_ce_n, m_oe_n;
  logic [12:0] d_a, m_a;
  logic [7:0]  d_d, m_d, dout1;
  logic        d_rdy, m_rdy, en1;
  logic [13:0] addr1;

  logic        x_dce_n, x_doe_n, x_mce_n, x_moe_n;
  logic [12:0] x_da, x_ma;
  logic [7:0]  x_dd, x_md, dout3;
  logic        x_drdy, x_mrdy, en3;
  logic [13:0] addr3;

  logic [7:0]  rom [16384];
  logic        s1_v, s2_v;
  logic [13:0] s1_a, s2_a;

  int nvec = 0;
  int nerr = 0;

  rom_socket_arbiter #(.MEM_LATENCY(1), .IDLE_DATA(8'hFF)) u_l1 (
    .clk_14M(clk), .reset_n(reset_n),
    .diag_ce_n(d_ce_n), .diag_oe_n(d_oe_n), .diag_a(d_a), .diag_d(d_d), .diag_rdy(d_rdy),
    .mon_ce_n(m_ce_n), .mon_oe_n(m_oe_n), .mon_a(m_a), .mon_d(m_d), .mon_rdy(m_rdy),
    .mem_en(en1), .mem_addr(addr1), .mem_dout(dout1)
  );

  rom_socket_arbiter #(.MEM_LATENCY(3), .IDLE_DATA(8'hFF)) u_l3 (
    .clk_14M(clk), .reset_n(reset_n),
    .diag_ce_n(x_dce_n), .diag_oe_n(x_doe_n), .diag_a(x_da), .diag_d(x_dd), .diag_rdy(x_drdy),
    .mon_ce_n(x_mce_n), .mon_oe_n(x_moe_n), .mon_a(x_ma), .mon_d(x_md), .mon_rdy(x_mrdy),
    .mem_en(en3), .mem_addr(addr3), .mem_dout(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle ROM: data appears after the edge that samples mem_en and is held.
  initial dout1 = 8'h00;
  always @(posedge clk) if (en1) dout1 <= rom[addr1];

  // 3-cycle ROM: data appears three edges after mem_en is sampled and is held.
  initial begin dout3 = 8'h00; s1_v = 1'b0; s2_v = 1'b0; s1_a = '0; s2_a = '0; end
  always @(posedge clk) begin
    s1_v <= en3;  s1_a <= addr3;
    s2_v <= s1_v; s2_a <= s1_a;
    if (s2_v) dout3 <= rom[s2_a];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 8'(i) ^ 8'h55;
    rom[14'h0005] = 8'hA9; rom[14'h3FFC] = 8'h62;
    rom[14'h0007] = 8'h3C; rom[14'h2007] = 8'hC3;
    rom[14'h0020] = 8'h11; rom[14'h0021] = 8'h44; rom[14'h2022] = 8'h22;
    rom[14'h0010] = 8'h5A; rom[14'h0011] = 8'hA5; rom[14'h0030] = 8'h9E;

    reset_n = 1'b0;
    d_ce_n = 1'b0; d_oe_n = 1'b0; d_a = 13'h0005;
    m_ce_n = 1'b0; m_oe_n = 1'b0; m_a = 13'h0000;
    x_dce_n = 1'b1; x_doe_n = 1'b1; x_da = '0;
    x_mce_n = 1'b0; x_moe_n = 1'b0; x_ma = '0;
    step(); step();

    // Reset state, sockets selected so d shows the reset data register.
    chk("rst_mem_en", 16'(en1), 16'h0);
    chk("rst_mem_addr", 16'(addr1), 16'h0000);
    chk("rst_diag_d", 16'(d_d), 16'h00FF);
    chk("rst_diag_rdy", 16'(d_rdy), 16'h0);
    chk("rst_mon_d", 16'(m_d), 16'h00FF);
    chk("rst_mon_rdy", 16'(m_rdy), 16'h0);
    chk("rst_l3_mon_d", 16'(x_md), 16'h00FF);
    chk("rst_l3_mon_rdy", 16'(x_mrdy), 16'h0);

    d_ce_n = 1'b1; m_ce_n = 1'b1; m_oe_n = 1'b1; x_mce_n = 1'b1;
    reset_n = 1'b1;
    step();
    chk("idle_mem_en", 16'(en1), 16'h0);

    // Single diagnostics read: rdy four cycles after the request.
    d_ce_n = 1'b0;
    step();
    chk("single_en", 16'(en1), 16'h1);
    chk("single_addr", 16'(addr1), 16'h0005);
    chk("single_rdy_c1", 16'(d_rdy), 16'h0);
    step();
    chk("single_en_c2", 16'(en1), 16'h0);
    step();
    chk("single_rdy_c3", 16'(d_rdy), 16'h0);
    step();
    chk("single_rdy_c4", 16'(d_rdy), 16'h1);
    chk("single_d", 16'(d_d), 16'h00A9);

    // Monitor socket maps to the upper half of the ROM.
    d_ce_n = 1'b1; m_ce_n = 1'b0; m_oe_n = 1'b0; m_a = 13'h1FFC;
    step();
    chk("mon_en", 16'(en1), 16'h1);
    chk("mon_addr", 16'(addr1), 16'h3FFC);
    step(); step(); step();
    chk("mon_rdy", 16'(m_rdy), 16'h1);
    chk("mon_d", 16'(m_d), 16'h0062);
    chk("mon_diag_rdy", 16'(d_rdy), 16'h0);
    chk("mon_diag_d", 16'(d_d), 16'h00FF);

    // Tie with monitor served last: diagnostics first, monitor four cycles later.
    d_ce_n = 1'b0; d_a = 13'h0007; m_a = 13'h0007;
    step();
    chk("tie1_en_a", 16'(en1), 16'h1);
    chk("tie1_addr_a", 16'(addr1), 16'h0007);
    step(); step(); step();
    chk("tie1_diag_rdy", 16'(d_rdy), 16'h1);
    chk("tie1_diag_d", 16'(d_d), 16'h003C);
    chk("tie1_mon_rdy_wait", 16'(m_rdy), 16'h0);
    step();
    chk("tie1_en_b", 16'(en1), 16'h1);
    chk("tie1_addr_b", 16'(addr1), 16'h2007);
    step(); step();
    chk("tie1_mon_rdy_c7", 16'(m_rdy), 16'h0);
    step();
    chk("tie1_mon_rdy", 16'(m_rdy), 16'h1);
    chk("tie1_mon_d", 16'(m_d), 16'h00C3);

    // Diagnostics-only read; stale data stays visible until rdy.
    d_a = 13'h0020;
    step();
    chk("stale_addr", 16'(addr1), 16'h0020);
    chk("stale_d", 16'(d_d), 16'h003C);
    chk("stale_rdy", 16'(d_rdy), 16'h0);
    step(); step(); step();
    chk("dx_rdy", 16'(d_rdy), 16'h1);
    chk("dx_d", 16'(d_d), 16'h0011);

    // Tie with diagnostics served last: monitor goes first.
    d_a = 13'h0021; m_a = 13'h0022;
    step();
    chk("tie2_addr_a", 16'(addr1), 16'h2022);
    step(); step(); step();
    chk("tie2_mon_rdy", 16'(m_rdy), 16'h1);
    chk("tie2_mon_d", 16'(m_d), 16'h0022);
    chk("tie2_diag_rdy_wait", 16'(d_rdy), 16'h0);
    step();
    chk("tie2_en_b", 16'(en1), 16'h1);
    chk("tie2_addr_b", 16'(addr1), 16'h0021);
    step(); step(); step();
    chk("tie2_diag_rdy", 16'(d_rdy), 16'h1);
    chk("tie2_diag_d", 16'(d_d), 16'h0044);

    // Cache hit on reselect, and oe gating of the data bus.
    d_ce_n = 1'b1;
    step();
    chk("hit_desel_rdy", 16'(d_rdy), 16'h0);
    chk("hit_desel_d", 16'(d_d), 16'h00FF);
    d_ce_n = 1'b0;
    #1;
    chk("hit_resel_rdy", 16'(d_rdy), 16'h1);
    chk("hit_resel_d", 16'(d_d), 16'h0044);
    step();
    chk("hit_no_en", 16'(en1), 16'h0);
    d_oe_n = 1'b1;
    #1;
    chk("oe_gate_d", 16'(d_d), 16'h00FF);
    chk("oe_gate_rdy", 16'(d_rdy), 16'h1);
    d_oe_n = 1'b0;

    // MEM_LATENCY=3: address changes during WAIT, old read completes, new one is issued.
    x_dce_n = 1'b0; x_doe_n = 1'b0; x_da = 13'h0010;
    step();
    chk("l3_en_a", 16'(en3), 16'h1);
    chk("l3_addr_a", 16'(addr3), 16'h0010);
    step();
    x_da = 13'h0011;
    step(); step(); step(); step();
    chk("l3_rdy_after_old", 16'(x_drdy), 16'h0);
    chk("l3_old_d", 16'(x_dd), 16'h005A);
    step();
    chk("l3_en_b", 16'(en3), 16'h1);
    chk("l3_addr_b", 16'(addr3), 16'h0011);
    step(); step(); step(); step();
    chk("l3_rdy_c11", 16'(x_drdy), 16'h0);
    step();
    chk("l3_rdy", 16'(x_drdy), 16'h1);
    chk("l3_d", 16'(x_dd), 16'h00A5);

    // Asynchronous reset during WAIT, then the still-pending request re-issues.
    d_a = 13'h0030;
    step();
    chk("rmid_en", 16'(en1), 16'h1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rmid_mem_en", 16'(en1), 16'h0);
    chk("rmid_mem_addr", 16'(addr1), 16'h0000);
    chk("rmid_rdy", 16'(d_rdy), 16'h0);
    chk("rmid_d", 16'(d_d), 16'h00FF);
    chk("rmid_mon_rdy", 16'(m_rdy), 16'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("rrel_en", 16'(en1), 16'h1);
    chk("rrel_addr", 16'(addr1), 16'h0030);
    step(); step(); step();
    chk("rrel_rdy", 16'(d_rdy), 16'h1);
    chk("rrel_d", 16'(d_d), 16'h009E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
